// File: rtl/armleocpu_clint_pkg.sv
// Shared constants, AXI response codes and FSM encoding for the CLINT mtimecmp reload master.
// Optional periodic re-arm is enabled with ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN.
package armleocpu_clint_pkg;

    localparam logic [31:0] MTIMECMP_OFFSET = 32'h0000_4000;
    localparam logic [31:0] MTIME_OFFSET    = 32'h0000_BFF8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_HI1,
        RD_LO,
        RD_HI2,
        CALC,
        WR_HI_ONES,
        WR_LO,
        WR_HI,
        DONE
    } reload_state_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/armleocpu_axi_lite_single_beat.sv
// One AXI4-Lite read or write beat: VALID/READY sequencing and response capture.
// Optional periodic re-arm (ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN) does not affect this block.
module armleocpu_axi_lite_single_beat (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [1:0]  resp,
    output logic [31:0] rdata,
    output logic [31:0] AXI_AWADDR,
    output logic        AXI_AWVALID,
    input  logic        AXI_AWREADY,
    output logic [31:0] AXI_WDATA,
    output logic [3:0]  AXI_WSTRB,
    output logic        AXI_WVALID,
    input  logic        AXI_WREADY,
    input  logic [1:0]  AXI_BRESP,
    input  logic        AXI_BVALID,
    output logic        AXI_BREADY,
    output logic [31:0] AXI_ARADDR,
    output logic        AXI_ARVALID,
    input  logic        AXI_ARREADY,
    input  logic [31:0] AXI_RDATA,
    input  logic [1:0]  AXI_RRESP,
    input  logic        AXI_RVALID,
    output logic        AXI_RREADY
);

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_pend;
    logic        w_pend;
    logic        wr_act;
    logic        ar_pend;
    logic        rd_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            wr_act  <= 1'b0;
            ar_pend <= 1'b0;
            rd_act  <= 1'b0;
        end else begin
            if (start) begin
                addr_q <= addr;
                if (write) begin
                    wdata_q <= wdata;
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                    wr_act  <= 1'b1;
                end else begin
                    ar_pend <= 1'b1;
                    rd_act  <= 1'b1;
                end
            end
            if (aw_pend && AXI_AWREADY) aw_pend <= 1'b0;
            if (w_pend && AXI_WREADY) w_pend <= 1'b0;
            if (ar_pend && AXI_ARREADY) ar_pend <= 1'b0;
            if (AXI_BVALID && AXI_BREADY) wr_act <= 1'b0;
            if (AXI_RVALID && AXI_RREADY) rd_act <= 1'b0;
        end
    end

    assign AXI_AWADDR  = addr_q;
    assign AXI_AWVALID = aw_pend;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = 4'hF;
    assign AXI_WVALID  = w_pend;
    // Response is only accepted once both address and data have been taken.
    assign AXI_BREADY  = wr_act && !aw_pend && !w_pend;
    assign AXI_ARADDR  = addr_q;
    assign AXI_ARVALID = ar_pend;
    assign AXI_RREADY  = rd_act && !ar_pend;

    assign done  = (AXI_BVALID && AXI_BREADY) || (AXI_RVALID && AXI_RREADY);
    assign resp  = rd_act ? AXI_RRESP : AXI_BRESP;
    assign rdata = AXI_RDATA;

endmodule

// File: rtl/armleocpu_clint_reload.sv
// Re-arms one hart's mtimecmp: rollover-safe mtime read, add delta, glitch-free hi/lo/hi write.
// Optional periodic mode (skip mtime read, use last target) via ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN.
module armleocpu_clint_reload
    import armleocpu_clint_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE       = 32'h0,
    parameter int          HART_COUNT       = 7,
    parameter int          HART_COUNT_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [HART_COUNT_WIDTH-1:0] cmd_hart,
    input  logic [31:0]                 cmd_delta,
`ifdef ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN
    input  logic                        cmd_periodic,
`endif
    output logic                        done,
    output logic                        error,
    output logic [31:0]                 AXI_AWADDR,
    output logic                        AXI_AWVALID,
    input  logic                        AXI_AWREADY,
    output logic [31:0]                 AXI_WDATA,
    output logic [3:0]                  AXI_WSTRB,
    output logic                        AXI_WVALID,
    input  logic                        AXI_WREADY,
    input  logic [1:0]                  AXI_BRESP,
    input  logic                        AXI_BVALID,
    output logic                        AXI_BREADY,
    output logic [31:0]                 AXI_ARADDR,
    output logic                        AXI_ARVALID,
    input  logic                        AXI_ARREADY,
    input  logic [31:0]                 AXI_RDATA,
    input  logic [1:0]                  AXI_RRESP,
    input  logic                        AXI_RVALID,
    output logic                        AXI_RREADY
);

    localparam logic [31:0] MTIME_LO = CLINT_BASE + MTIME_OFFSET;
    localparam logic [31:0] MTIME_HI = MTIME_LO + 32'd4;

    reload_state_t               state_q, state_d;
    logic [HART_COUNT_WIDTH-1:0] hart_q;
    logic [31:0]                 delta_q;
    logic [31:0]                 hi_q;
    logic [31:0]                 lo_q;
    logic [63:0]                 target_q;
    logic                        err_q;
    logic                        issued_q;

    logic        bus_state;
    logic        beat_start;
    logic        beat_write;
    logic [31:0] beat_addr;
    logic [31:0] beat_wdata;
    logic        beat_done;
    logic [1:0]  beat_resp;
    logic [31:0] beat_rdata;
    logic        beat_err;
    logic        hart_bad;
    logic [31:0] cmp_lo;
    logic [31:0] cmp_hi;

`ifdef ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN
    logic [63:0] last_target [HART_COUNT];
`endif

    assign hart_bad   = int'(cmd_hart) >= HART_COUNT;
    assign beat_err   = resp_is_err(beat_resp);
    assign cmp_lo     = CLINT_BASE + MTIMECMP_OFFSET + 32'({hart_q, 3'b000});
    assign cmp_hi     = cmp_lo + 32'd4;
    assign beat_start = bus_state && !issued_q;
    assign cmd_ready  = state_q == IDLE;
    assign done       = state_q == DONE;
    assign error      = (state_q == DONE) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        bus_state  = 1'b1;
        beat_write = 1'b0;
        beat_addr  = 32'h0;
        beat_wdata = 32'h0;
        unique case (state_q)
            IDLE: begin
                bus_state = 1'b0;
                if (cmd_valid) begin
                    if (hart_bad) state_d = DONE;
`ifdef ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN
                    else if (cmd_periodic) state_d = CALC;
`endif
                    else state_d = RD_HI1;
                end
            end
            RD_HI1: begin
                beat_addr = MTIME_HI;
                if (beat_done) state_d = beat_err ? DONE : RD_LO;
            end
            RD_LO: begin
                beat_addr = MTIME_LO;
                if (beat_done) state_d = beat_err ? DONE : RD_HI2;
            end
            RD_HI2: begin
                beat_addr = MTIME_HI;
                if (beat_done) begin
                    if (beat_err)               state_d = DONE;
                    else if (beat_rdata != hi_q) state_d = RD_LO;
                    else                        state_d = CALC;
                end
            end
            CALC: begin
                bus_state = 1'b0;
                state_d   = WR_HI_ONES;
            end
            WR_HI_ONES: begin
                beat_write = 1'b1;
                beat_addr  = cmp_hi;
                beat_wdata = 32'hFFFF_FFFF;
                if (beat_done) state_d = beat_err ? DONE : WR_LO;
            end
            WR_LO: begin
                beat_write = 1'b1;
                beat_addr  = cmp_lo;
                beat_wdata = target_q[31:0];
                if (beat_done) state_d = beat_err ? DONE : WR_HI;
            end
            WR_HI: begin
                beat_write = 1'b1;
                beat_addr  = cmp_hi;
                beat_wdata = target_q[63:32];
                if (beat_done) state_d = DONE;
            end
            DONE: begin
                bus_state = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                bus_state = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hart_q   <= '0;
            delta_q  <= 32'h0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            target_q <= 64'h0;
            err_q    <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            if (beat_start) issued_q <= 1'b1;
            if (beat_done) begin
                issued_q <= 1'b0;
                if (beat_err) err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: if (cmd_valid) begin
                    hart_q  <= cmd_hart;
                    delta_q <= cmd_delta;
                    err_q   <= hart_bad;
`ifdef ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN
                    if (!hart_bad && cmd_periodic) {hi_q, lo_q} <= last_target[cmd_hart];
`endif
                end
                RD_HI1, RD_HI2: if (beat_done) hi_q <= beat_rdata;
                RD_LO: if (beat_done) lo_q <= beat_rdata;
                CALC: target_q <= {hi_q, lo_q} + {32'h0, delta_q};
                default: ;
            endcase
        end
    end

`ifdef ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HART_COUNT; i++) last_target[i] <= 64'h0;
        end else if (state_q == WR_HI && beat_done && !beat_err) begin
            last_target[hart_q] <= target_q;
        end
    end
`endif

    armleocpu_axi_lite_single_beat u_beat (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (beat_start),
        .write       (beat_write),
        .addr        (beat_addr),
        .wdata       (beat_wdata),
        .done        (beat_done),
        .resp        (beat_resp),
        .rdata       (beat_rdata),
        .AXI_AWADDR  (AXI_AWADDR),
        .AXI_AWVALID (AXI_AWVALID),
        .AXI_AWREADY (AXI_AWREADY),
        .AXI_WDATA   (AXI_WDATA),
        .AXI_WSTRB   (AXI_WSTRB),
        .AXI_WVALID  (AXI_WVALID),
        .AXI_WREADY  (AXI_WREADY),
        .AXI_BRESP   (AXI_BRESP),
        .AXI_BVALID  (AXI_BVALID),
        .AXI_BREADY  (AXI_BREADY),
        .AXI_ARADDR  (AXI_ARADDR),
        .AXI_ARVALID (AXI_ARVALID),
        .AXI_ARREADY (AXI_ARREADY),
        .AXI_RDATA   (AXI_RDATA),
        .AXI_RRESP   (AXI_RRESP),
        .AXI_RVALID  (AXI_RVALID),
        .AXI_RREADY  (AXI_RREADY)
    );

endmodule

// File: tb/tb_armleocpu_clint_reload.sv
// Directed bench for armleocpu_clint_reload with a stalling AXI4-Lite slave model.
// Periodic mode (ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN) only ties the extra port low here.
module tb_armleocpu_clint_reload;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_hart;
    logic [31:0] cmd_delta;
    logic        done;
    logic        error;
    logic [31:0] AXI_AWADDR;
    logic        AXI_AWVALID;
    logic        AXI_AWREADY;
    logic [31:0] AXI_WDATA;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_WVALID;
    logic        AXI_WREADY;
    logic [1:0]  AXI_BRESP;
    logic        AXI_BVALID;
    logic        AXI_BREADY;
    logic [31:0] AXI_ARADDR;
    logic        AXI_ARVALID;
    logic        AXI_ARREADY;
    logic [31:0] AXI_RDATA;
    logic [1:0]  AXI_RRESP;
    logic        AXI_RVALID;
    logic        AXI_RREADY;
`ifdef ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN
    logic        cmd_periodic = 1'b0;
`endif

    always #5 clk = ~clk;

    armleocpu_clint_reload dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_hart    (cmd_hart),
        .cmd_delta   (cmd_delta),
`ifdef ARMLEOCPU_CLINT_RELOAD_PERIODIC_EN
        .cmd_periodic(cmd_periodic),
`endif
        .done        (done),
        .error       (error),
        .AXI_AWADDR  (AXI_AWADDR),
        .AXI_AWVALID (AXI_AWVALID),
        .AXI_AWREADY (AXI_AWREADY),
        .AXI_WDATA   (AXI_WDATA),
        .AXI_WSTRB   (AXI_WSTRB),
        .AXI_WVALID  (AXI_WVALID),
        .AXI_WREADY  (AXI_WREADY),
        .AXI_BRESP   (AXI_BRESP),
        .AXI_BVALID  (AXI_BVALID),
        .AXI_BREADY  (AXI_BREADY),
        .AXI_ARADDR  (AXI_ARADDR),
        .AXI_ARVALID (AXI_ARVALID),
        .AXI_ARREADY (AXI_ARREADY),
        .AXI_RDATA   (AXI_RDATA),
        .AXI_RRESP   (AXI_RRESP),
        .AXI_RVALID  (AXI_RVALID),
        .AXI_RREADY  (AXI_RREADY)
    );

    int checks = 0;
    int errors = 0;

    int          stall_max;
    bit          w_first;
    int          bresp_err_idx;
    logic [1:0]  rresp_cfg;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          aw_have, w_have, b_pend, r_pend;
    logic [31:0] aw_addr_r, w_data_r;
    logic [1:0]  b_resp_r;
    bit          pv_aw, pv_w, pv_ar;
    logic [31:0] pa_aw, pd_w, pa_ar;
    int          stab_err, overlap_err;
    logic [31:0] rd_data[$];
    logic [31:0] rd_log[$];
    logic [63:0] wr_log[$];
    logic [31:0] exp_rd[$];
    logic [63:0] exp_wr[$];

    function automatic int rnd();
        return (stall_max == 0) ? 0 : int'($urandom_range(stall_max, 0));
    endfunction

    task automatic load_w_stalls();
        w_cnt  = rnd();
        aw_cnt = w_first ? w_cnt + 1 : rnd();
    endtask

    task automatic slave_clear(input int smax, input bit wf);
        stall_max = smax; w_first = wf;
        bresp_err_idx = -1; rresp_cfg = 2'b00;
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        pv_aw = 0; pv_w = 0; pv_ar = 0;
        stab_err = 0; overlap_err = 0;
        rd_data.delete(); rd_log.delete(); wr_log.delete();
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0;
        AXI_BVALID = 0; AXI_BRESP = 0;
        AXI_RVALID = 0; AXI_RRESP = 0; AXI_RDATA = 0;
        load_w_stalls();
        ar_cnt = rnd();
    endtask

    // Slave: observe handshakes on the active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (pv_aw && !(AXI_AWVALID && AXI_AWADDR == pa_aw)) stab_err++;
            if (pv_w && !(AXI_WVALID && AXI_WDATA == pd_w)) stab_err++;
            if (pv_ar && !(AXI_ARVALID && AXI_ARADDR == pa_ar)) stab_err++;
            pv_aw = AXI_AWVALID && !AXI_AWREADY; pa_aw = AXI_AWADDR;
            pv_w  = AXI_WVALID && !AXI_WREADY;   pd_w  = AXI_WDATA;
            pv_ar = AXI_ARVALID && !AXI_ARREADY; pa_ar = AXI_ARADDR;
            if ((AXI_AWVALID || AXI_WVALID || AXI_BREADY) && (AXI_ARVALID || AXI_RREADY))
                overlap_err++;
            if (AXI_AWVALID && AXI_AWREADY) begin aw_have = 1; aw_addr_r = AXI_AWADDR; end
            if (AXI_WVALID && AXI_WREADY) begin w_have = 1; w_data_r = AXI_WDATA; end
            if (AXI_BVALID && AXI_BREADY) begin b_pend = 0; load_w_stalls(); end
            if (aw_have && w_have) begin
                wr_log.push_back({aw_addr_r, w_data_r});
                b_resp_r = (wr_log.size() - 1 == bresp_err_idx) ? 2'b10 : 2'b00;
                b_pend = 1; b_cnt = rnd();
                aw_have = 0; w_have = 0;
            end
            if (AXI_ARVALID && AXI_ARREADY) begin
                rd_log.push_back(AXI_ARADDR);
                r_pend = 1; r_cnt = rnd(); ar_cnt = rnd();
            end
            if (AXI_RVALID && AXI_RREADY) begin
                r_pend = 0;
                if (rd_data.size() > 0) void'(rd_data.pop_front());
            end
        end
    end

    // Slave: drive ready/valid on the opposite edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (AXI_AWVALID && !aw_have) begin
                if (aw_cnt > 0) begin aw_cnt--; AXI_AWREADY = 0; end
                else AXI_AWREADY = 1;
            end else AXI_AWREADY = 0;
            if (AXI_WVALID && !w_have) begin
                if (w_cnt > 0) begin w_cnt--; AXI_WREADY = 0; end
                else AXI_WREADY = 1;
            end else AXI_WREADY = 0;
            if (AXI_ARVALID) begin
                if (ar_cnt > 0) begin ar_cnt--; AXI_ARREADY = 0; end
                else AXI_ARREADY = 1;
            end else AXI_ARREADY = 0;
            if (b_pend && b_cnt > 0) begin b_cnt--; AXI_BVALID = 0; end
            else if (b_pend) begin AXI_BVALID = 1; AXI_BRESP = b_resp_r; end
            else begin AXI_BVALID = 0; AXI_BRESP = 0; end
            if (r_pend && r_cnt > 0) begin r_cnt--; AXI_RVALID = 0; end
            else if (r_pend) begin
                AXI_RVALID = 1; AXI_RRESP = rresp_cfg;
                AXI_RDATA = (rd_data.size() > 0) ? rd_data[0] : 32'hDEAD_BEEF;
            end else begin AXI_RVALID = 0; AXI_RRESP = 0; end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic er(input logic [31:0] a);
        exp_rd.push_back(a);
    endtask

    task automatic ew(input logic [31:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic check_traffic(input string tag);
        chk({tag, "_nrd"}, 64'(rd_log.size()), 64'(exp_rd.size()));
        chk({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_rd.size(); i++)
            chk({tag, "_rd"}, (i < rd_log.size()) ? 64'(rd_log[i]) : 64'hBAD, 64'(exp_rd[i]));
        for (int i = 0; i < exp_wr.size(); i++)
            chk({tag, "_wr"}, (i < wr_log.size()) ? wr_log[i] : 64'hBAD, exp_wr[i]);
        chk({tag, "_stable"}, 64'(stab_err), 64'd0);
        chk({tag, "_overlap"}, 64'(overlap_err), 64'd0);
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] h, input logic [31:0] d,
                           input logic exp_err, output int cyc);
        bit got;
        logic e;
        got = 0; e = 0; cyc = 0;
        @(negedge clk);
        cmd_hart = h; cmd_delta = d; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        chk({tag, "_busy"}, cmd_ready, 0);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin got = 1; e = error; end
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_error"}, e, exp_err);
        @(negedge clk);
        chk({tag, "_pulse_ready"}, {done, cmd_ready}, 2'b01);
    endtask

    int  cyc;
    bit  found;

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_hart = 0; cmd_delta = 0;
        slave_clear(0, 0);
        repeat (3) @(negedge clk);
        chk("reset_valids",
            {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
        chk("reset_done_err", {done, error}, 0);
        chk("reset_addr", {AXI_AWADDR, AXI_ARADDR}, 0);
        chk("reset_wdata", AXI_WDATA, 0);
        rst_n = 1;
        @(negedge clk);
        chk("reset_ready", cmd_ready, 1);

        slave_clear(0, 0);
        rd_data.push_back(32'h1); rd_data.push_back(32'h10); rd_data.push_back(32'h1);
        run_cmd("basic", 3'd2, 32'h100, 1'b0, cyc);
        er(32'hBFFC); er(32'hBFF8); er(32'hBFFC);
        ew(32'h4014, 32'hFFFF_FFFF); ew(32'h4010, 32'h110); ew(32'h4014, 32'h1);
        check_traffic("basic");
        chk("basic_wstrb", AXI_WSTRB, 4'hF);

        slave_clear(0, 0);
        rd_data.push_back(32'h0); rd_data.push_back(32'hFFFF_FFFF);
        rd_data.push_back(32'h1); rd_data.push_back(32'h5); rd_data.push_back(32'h1);
        run_cmd("roll", 3'd0, 32'h20, 1'b0, cyc);
        er(32'hBFFC); er(32'hBFF8); er(32'hBFFC); er(32'hBFF8); er(32'hBFFC);
        ew(32'h4004, 32'hFFFF_FFFF); ew(32'h4000, 32'h25); ew(32'h4004, 32'h1);
        check_traffic("roll");

        slave_clear(6, 1);
        rd_data.push_back(32'h2); rd_data.push_back(32'h8000_0000); rd_data.push_back(32'h2);
        run_cmd("stall_wfirst", 3'd6, 32'hFFFF_FFFF, 1'b0, cyc);
        er(32'hBFFC); er(32'hBFF8); er(32'hBFFC);
        ew(32'h4034, 32'hFFFF_FFFF); ew(32'h4030, 32'h7FFF_FFFF); ew(32'h4034, 32'h3);
        check_traffic("stall_wfirst");

        slave_clear(7, 0);
        rd_data.push_back(32'hFFFF_FFFF); rd_data.push_back(32'hFFFF_FF00);
        rd_data.push_back(32'hFFFF_FFFF);
        run_cmd("wrap", 3'd1, 32'h200, 1'b0, cyc);
        er(32'hBFFC); er(32'hBFF8); er(32'hBFFC);
        ew(32'h400C, 32'hFFFF_FFFF); ew(32'h4008, 32'h100); ew(32'h400C, 32'h0);
        check_traffic("wrap");

        slave_clear(2, 0);
        bresp_err_idx = 1;
        rd_data.push_back(32'h0); rd_data.push_back(32'h0); rd_data.push_back(32'h0);
        run_cmd("slverr", 3'd3, 32'h5, 1'b1, cyc);
        er(32'hBFFC); er(32'hBFF8); er(32'hBFFC);
        ew(32'h401C, 32'hFFFF_FFFF); ew(32'h4018, 32'h5);
        check_traffic("slverr");

        slave_clear(0, 0);
        rresp_cfg = 2'b11;
        rd_data.push_back(32'h7);
        run_cmd("decerr", 3'd5, 32'h5, 1'b1, cyc);
        er(32'hBFFC);
        check_traffic("decerr");

        slave_clear(0, 0);
        run_cmd("badhart", 3'd7, 32'h5, 1'b1, cyc);
        chk("badhart_latency", 64'(cyc), 64'd1);
        check_traffic("badhart");

        slave_clear(3, 0);
        rd_data.push_back(32'h0); rd_data.push_back(32'h1000); rd_data.push_back(32'h0);
        @(negedge clk);
        cmd_hart = 3'd4; cmd_delta = 32'h10; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (AXI_AWVALID && AXI_AWADDR == 32'h4020) found = 1;
        end
        chk("midrst_reached_wr_lo", found, 1);
        rst_n = 0;
        #1;
        chk("midrst_valids",
            {AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 0);
        chk("midrst_done", {done, error}, 0);
        repeat (2) @(negedge clk);
        chk("midrst_hold", done, 0);
        rst_n = 1;
        slave_clear(0, 0);
        @(negedge clk);
        chk("midrst_ready", cmd_ready, 1);

        rd_data.push_back(32'hA); rd_data.push_back(32'hB); rd_data.push_back(32'hA);
        run_cmd("after_rst", 3'd4, 32'h1, 1'b0, cyc);
        er(32'hBFFC); er(32'hBFF8); er(32'hBFFC);
        ew(32'h4024, 32'hFFFF_FFFF); ew(32'h4020, 32'hC); ew(32'h4024, 32'hA);
        check_traffic("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
